// File: rtl/seq_divider.sv
// ============================================================================
// Module   : seq_divider
// Purpose  : 32-bit restoring divider. It produces one quotient bit per cycle,
//            so an operation takes 32 RUN cycles followed by a one-cycle DONE
//            pulse.
// Options  : define SEQ_DIVIDER_SIGNED_EN to honour is_signed (DIV semantics).
//            Without it every operation is unsigned (DIVU).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_step;      // index of the restoring step being performed
  logic [31:0] r_rem;       // partial remainder
  logic [31:0] r_quo;       // dividend bits shift out MSB-first, quotient bits shift in
  logic [31:0] r_dvs;       // divisor magnitude
  logic        r_neg_q;     // quotient must be negated at the end
  logic        r_neg_r;     // remainder must be negated at the end
  logic        r_zero;      // sampled divisor was zero

  logic        w_signed;
  logic        w_dvd_neg;
  logic        w_dvs_neg;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [32:0] w_shift;
  logic [33:0] w_trial;
  logic        w_fits;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_q_final;
  logic [31:0] w_r_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign w_signed = is_signed;
`else
  // is_signed is ignored in the unsigned-only build.
  assign w_signed = is_signed & 1'b0;
`endif

  // Operand magnitudes and sign bookkeeping, captured when start is accepted.
  assign w_dvd_neg = w_signed & dividend[31];
  assign w_dvs_neg = w_signed & divisor[31];
  assign w_dvd_mag = w_dvd_neg ? (~dividend + 32'd1) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (~divisor + 32'd1) : divisor;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_trial    = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_fits     = ~w_trial[33];
  assign w_rem_next = w_fits ? w_trial[31:0] : w_shift[31:0];
  assign w_quo_next = {r_quo[30:0], w_fits};

  // Sign fix-up. A zero divisor always reports all-ones, whatever the signs;
  // the remainder then equals the original dividend, because the magnitude
  // is re-negated.
  assign w_q_final = r_zero  ? 32'hFFFF_FFFF
                   : r_neg_q ? (~w_quo_next + 32'd1) : w_quo_next;
  assign w_r_final = r_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (r_step == 5'd31) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath. The results load only on the final RUN step, that is, on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step      <= 5'd0;
      r_rem       <= 32'd0;
      r_quo       <= 32'd0;
      r_dvs       <= 32'd0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_step  <= 5'd0;
            r_rem   <= 32'd0;
            r_quo   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_zero  <= (divisor == 32'd0);
          end
        end
        RUN: begin
          r_rem  <= w_rem_next;
          r_quo  <= w_quo_next;
          r_step <= r_step + 5'd1;
          if (r_step == 5'd31) begin
            quotient    <= w_q_final;
            remainder   <= w_r_final;
            div_by_zero <= r_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Scoreboard bench for seq_divider. Expected results come from
//            SystemVerilog's / and % operators and are queued when an
//            operation starts. They are popped when done pulses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];

  seq_divider dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference results, computed from the arithmetic definition.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic signed [31:0] sa;
    logic signed [31:0] sb_;
    logic sgn;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sgn = s;
`else
    sgn = 1'b0 & s;
`endif
    sa  = a;
    sb_ = b;
    e.z = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.z = 1'b1;
    end else if (!sgn) begin
      e.q = a / b; e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0;
    end else begin
      e.q = sa / sb_; e.r = sa % sb_;
    end
    return e;
  endfunction

  // Start one operation. Optionally pulse start again at cycle pulse_at with
  // other operands, then watch busy, done, the popped results and their hold.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int pulse_at, input logic [31:0] a2, input logic [31:0] b2);
    exp_t e;
    int   done_cyc = 0;
    int   done_cnt = 0;
    bit   busy_bad = 0;
    bit   popped   = 0;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (busy !== (c <= 32)) busy_bad = 1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        if (!popped) begin
          popped = 1;
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL done_unexpected: done with empty scoreboard at cycle %0d", c);
          end else begin
            e = sb.pop_front();
            tests++;
            if (quotient !== e.q) begin
              fails++;
              $display("FAIL quotient %h/%h s=%b: got %h expected %h", a, b, s, quotient, e.q);
            end
            tests++;
            if (remainder !== e.r) begin
              fails++;
              $display("FAIL remainder %h/%h s=%b: got %h expected %h", a, b, s, remainder, e.r);
            end
            tests++;
            if (div_by_zero !== e.z) begin
              fails++;
              $display("FAIL div_by_zero %h/%h: got %b expected %b", a, b, div_by_zero, e.z);
            end
          end
        end
      end
      if (c == 35 && popped) begin
        tests++;
        if (quotient !== e.q || remainder !== e.r) begin
          fails++;
          $display("FAIL result_hold %h/%h: got %h/%h expected %h/%h", a, b, quotient, remainder, e.q, e.r);
        end
      end
      if (c == pulse_at) begin
        start = 1'b1; dividend = a2; divisor = b2;
      end else begin
        start = 1'b0; dividend = $urandom; divisor = $urandom;
      end
    end
    start = 1'b0;
    tests++;
    if (done_cyc != 33 || done_cnt != 1) begin
      fails++;
      $display("FAIL done_timing %h/%h: first done at cycle %0d count %0d, expected cycle 33 count 1", a, b, done_cyc, done_cnt);
    end
    tests++;
    if (busy_bad) begin
      fails++;
      $display("FAIL busy_window %h/%h: busy not high exactly in cycles 1..32", a, b);
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_leftover: %0d entries remain", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    tests++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      fails++;
      $display("FAIL %s: got busy=%b done=%b q=%h r=%h z=%b expected all 0", tag, busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("idle_after_reset");
  endtask

  task automatic test_basic();
    run_op(32'd100, 32'd7, 1'b0, 0, '0, '0);
  endtask

  task automatic test_unsigned();
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, '0, '0);
    run_op(32'd5, 32'd9, 1'b0, 0, '0, '0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, '0, '0);
    for (int i = 0; i < 4; i++)
      run_op($urandom, $urandom_range(1, 32'h0001_0000) << (i * 4), 1'b0, 0, '0, '0);
  endtask

  task automatic test_div_zero();
    run_op(32'd5, 32'd0, 1'b0, 0, '0, '0);
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0, '0, '0);
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, '0, '0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, '0, '0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] b;
      b = $urandom;
      if (b == 32'd0) b = 32'd3;
      run_op($urandom, b, 1'b1, 0, '0, '0);
    end
  endtask

  task automatic test_back_to_back();
    run_op(32'd100, 32'd7, 1'b0, 10, 32'd9, 32'd3);
    run_op(32'd100, 32'd7, 1'b0, 33, 32'd9, 32'd3);
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_zero_outputs("reset_abort_immediate");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    tests++;
    if (dones != 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
    end
    run_op(32'd9, 32'd3, 1'b0, 0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have port is_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-005 SHALL have port dividend  input  32  numerator; sampled with start.
REQ-006 SHALL have port divisor  input  32  denominator; sampled with start.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-009 SHALL have port quotient  output  32  LO result.
REQ-010 SHALL have port remainder  output  32  HI result.
REQ-011 SHALL have port div_by_zero  output  1  set with done when the sampled divisor == 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE with start=1 SHALL latch operands, clear the step counter, and enter RUN next cycle.
- start=0 SHALL leave IDLE unchanged.
REQ-014 RUN SHALL perform one restoring step per cycle:
- shift partial remainder left 1, bringing in the next dividend bit (MSB first).
- trial-subtract the divisor (33-bit).
- if the trial result is non-negative: keep it and set quotient bit = 1; otherwise restore and set quotient bit = 0.
REQ-015 RUN SHALL last exactly 32 cycles, then enter DONE.
REQ-016 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
- Result: done is high 33 cycles after the start-sampling edge.
REQ-017 quotient, remainder and div_by_zero SHALL update only on entry to DONE, and hold until the next DONE or reset.
REQ-018 start asserted in RUN or DONE SHALL be ignored (no queuing, no restart).
REQ-019 start asserted in the same cycle DONE returns to IDLE SHALL NOT be accepted; it is accepted only when sampled in IDLE.
REQ-020 Divisor == 0 SHALL still take full latency and produce quotient=0xFFFFFFFF, remainder=dividend, div_by_zero=1.
- This holds in both signed and unsigned modes.
REQ-021 Unsigned mode SHALL produce floor(dividend/divisor) and dividend mod divisor.
REQ-022 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, step counter=0.
REQ-024 reset asserted in RUN SHALL abort the operation; no done pulse for it SHALL appear after release.
REQ-025 The first start after reset release SHALL be accepted normally.

Configuration
REQ-026 Macro SEQ_DIVIDER_SIGNED_EN SHALL control signed support.
REQ-027 With SEQ_DIVIDER_SIGNED_EN defined, is_signed=1 SHALL:
- divide operand magnitudes;
- negate the quotient when the operand signs differ;
- give the remainder the sign of the dividend (truncation toward zero);
- produce quotient=0x80000000, remainder=0 for 0x80000000 / 0xFFFFFFFF.
REQ-028 Without SEQ_DIVIDER_SIGNED_EN, is_signed SHALL be ignored and all operations SHALL be unsigned.
- Latency SHALL be identical in both builds.

Verification
REQ-029 reset, then start with 100 / 7 unsigned -> busy for 32 cycles; done 33 cycles after start; quotient=14, remainder=2, div_by_zero=0.
REQ-030 0xFFFFFFFF / 0x00000001 unsigned -> quotient=0xFFFFFFFF, remainder=0; then 5 / 9 -> quotient=0, remainder=5.
REQ-031 5 / 0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1 after 33 cycles.
REQ-032 With SEQ_DIVIDER_SIGNED_EN: -7 / 2 signed -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 0x80000000 / -1 -> quotient=0x80000000, remainder=0. Without the macro: -7 / 2 -> quotient=0x7FFFFFFC, remainder=1.
REQ-033 start 100 / 7, re-pulse start with 9 / 3 at cycle 10 -> ignored; single done at cycle 33 with quotient=14, remainder=2.
REQ-034 start 100 / 7, assert reset at cycle 15 -> all outputs 0 immediately; no done pulse within 40 cycles; next start 9 / 3 -> quotient=3, remainder=0.
